// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM (one-cycle read latency)
// between an instruction-fetch port (0) and a data/debug port (1).
// Grants are combinational from the requests, at most one access is issued
// per cycle, and each response is routed back to its owner one cycle later.
module sram_port_arbiter #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32,
   parameter int FIXED_PRIO = 0
) (
   input  logic                    clk,
   input  logic                    rstn_i,
   input  logic                    p0_req_i,
   output logic                    p0_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
   input  logic                    p0_we_i,
   input  logic [DATA_WIDTH/8-1:0] p0_be_i,
   input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
   output logic                    p0_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p0_rdata_o,
   input  logic                    p1_req_i,
   output logic                    p1_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
   input  logic                    p1_we_i,
   input  logic [DATA_WIDTH/8-1:0] p1_be_i,
   input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
   output logic                    p1_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p1_rdata_o,
   output logic                    ram_en_o,
   output logic                    ram_we_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic [DATA_WIDTH/8-1:0] ram_be_o,
   output logic [DATA_WIDTH-1:0]   ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
   output logic [15:0]             conflict_cnt_o
);

   logic        last_gnt_q, last_gnt_d;
   logic        rsp_pend_q, rsp_pend_d;
   logic        rsp_owner_q, rsp_owner_d;
   logic [15:0] conflict_cnt_q, conflict_cnt_d;

   logic both_req;
   logic gnt0;
   logic gnt1;
   logic rsp_live;

   // Arbitration: a lone requester always wins; on conflict either port 0
   // (fixed priority) or the port that lost the previous conflict wins.
   // Reset masks every grant so nothing reaches the RAM.
   always_comb begin
      both_req = p0_req_i & p1_req_i;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      if (rstn_i) begin
         if (both_req) begin
            if ((FIXED_PRIO != 0) || last_gnt_q) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
         end else begin
            gnt0 = p0_req_i;
            gnt1 = p1_req_i;
         end
      end
   end

   assign p0_gnt_o = gnt0;
   assign p1_gnt_o = gnt1;

   // RAM mux: the payload follows the granted port; port 0 is shown when idle.
   always_comb begin
      ram_en_o    = gnt0 | gnt1;
      ram_we_o    = ram_en_o & (gnt1 ? p1_we_i : p0_we_i);
      ram_addr_o  = gnt1 ? p1_addr_i  : p0_addr_i;
      ram_be_o    = gnt1 ? p1_be_i    : p0_be_i;
      ram_wdata_o = gnt1 ? p1_wdata_i : p0_wdata_i;
   end

   // Next-state: conflict history, response tracking, saturating counter.
   always_comb begin
      last_gnt_d     = last_gnt_q;
      rsp_pend_d     = gnt0 | gnt1;
      rsp_owner_d    = gnt1;
      conflict_cnt_d = conflict_cnt_q;
      if (both_req && (FIXED_PRIO == 0)) begin
         last_gnt_d = gnt1;
      end
      if (both_req && (conflict_cnt_q != 16'hFFFF)) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
   end

   // State registers; reset drops any outstanding response.
   always_ff @(posedge clk) begin
      if (!rstn_i) begin
         last_gnt_q     <= 1'b1;
         rsp_pend_q     <= 1'b0;
         rsp_owner_q    <= 1'b0;
         conflict_cnt_q <= 16'd0;
      end else begin
         last_gnt_q     <= last_gnt_d;
         rsp_pend_q     <= rsp_pend_d;
         rsp_owner_q    <= rsp_owner_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   // Response routing: only the owner of last cycle's access sees data.
   always_comb begin
      rsp_live    = rstn_i & rsp_pend_q;
      p0_rvalid_o = rsp_live & ~rsp_owner_q;
      p1_rvalid_o = rsp_live & rsp_owner_q;
      p0_rdata_o  = p0_rvalid_o ? ram_rdata_i : '0;
      p1_rdata_o  = p1_rvalid_o ? ram_rdata_i : '0;
   end

   assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a round-robin instance (a) and a
// fixed-priority instance (b) share the same stimulus, each with its own
// behavioural SRAM model.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [14:0] p0_addr, p1_addr;
   logic [3:0]  p0_be, p1_be;
   logic [31:0] p0_wdata, p1_wdata;

   logic        a_p0_gnt, a_p1_gnt, a_p0_rvalid, a_p1_rvalid, a_ram_en, a_ram_we;
   logic [31:0] a_p0_rdata, a_p1_rdata, a_ram_wdata, a_ram_rdata;
   logic [14:0] a_ram_addr;
   logic [3:0]  a_ram_be;
   logic [15:0] a_cnt;

   logic        b_p0_gnt, b_p1_gnt, b_p0_rvalid, b_p1_rvalid, b_ram_en, b_ram_we;
   logic [31:0] b_p0_rdata, b_p1_rdata, b_ram_wdata, b_ram_rdata;
   logic [14:0] b_ram_addr;
   logic [3:0]  b_ram_be;
   logic [15:0] b_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .FIXED_PRIO(0)) dut_a (
      .clk(clk), .rstn_i(rstn),
      .p0_req_i(p0_req), .p0_gnt_o(a_p0_gnt), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
      .p0_be_i(p0_be), .p0_wdata_i(p0_wdata), .p0_rvalid_o(a_p0_rvalid), .p0_rdata_o(a_p0_rdata),
      .p1_req_i(p1_req), .p1_gnt_o(a_p1_gnt), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
      .p1_be_i(p1_be), .p1_wdata_i(p1_wdata), .p1_rvalid_o(a_p1_rvalid), .p1_rdata_o(a_p1_rdata),
      .ram_en_o(a_ram_en), .ram_we_o(a_ram_we), .ram_addr_o(a_ram_addr), .ram_be_o(a_ram_be),
      .ram_wdata_o(a_ram_wdata), .ram_rdata_i(a_ram_rdata), .conflict_cnt_o(a_cnt)
   );

   sram_port_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .FIXED_PRIO(1)) dut_b (
      .clk(clk), .rstn_i(rstn),
      .p0_req_i(p0_req), .p0_gnt_o(b_p0_gnt), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
      .p0_be_i(p0_be), .p0_wdata_i(p0_wdata), .p0_rvalid_o(b_p0_rvalid), .p0_rdata_o(b_p0_rdata),
      .p1_req_i(p1_req), .p1_gnt_o(b_p1_gnt), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
      .p1_be_i(p1_be), .p1_wdata_i(p1_wdata), .p1_rvalid_o(b_p1_rvalid), .p1_rdata_o(b_p1_rdata),
      .ram_en_o(b_ram_en), .ram_we_o(b_ram_we), .ram_addr_o(b_ram_addr), .ram_be_o(b_ram_be),
      .ram_wdata_o(b_ram_wdata), .ram_rdata_i(b_ram_rdata), .conflict_cnt_o(b_cnt)
   );

   // Behavioural single-port SRAMs: byte-enabled write, registered read.
   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];

   always @(posedge clk) begin
      if (a_ram_en) begin
         if (a_ram_we) begin
            for (int i = 0; i < 4; i++)
               if (a_ram_be[i]) mem_a[a_ram_addr[9:2]][i*8 +: 8] <= a_ram_wdata[i*8 +: 8];
         end else begin
            a_ram_rdata <= mem_a[a_ram_addr[9:2]];
         end
      end
   end

   always @(posedge clk) begin
      if (b_ram_en) begin
         if (b_ram_we) begin
            for (int i = 0; i < 4; i++)
               if (b_ram_be[i]) mem_b[b_ram_addr[9:2]][i*8 +: 8] <= b_ram_wdata[i*8 +: 8];
         end else begin
            b_ram_rdata <= mem_b[b_ram_addr[9:2]];
         end
      end
   end

   task automatic idle_inputs();
      p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_be = 4'hF; p0_wdata = '0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_be = 4'hF; p1_wdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      idle_inputs();
      p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b1; p1_we = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({a_p0_gnt, a_p1_gnt, a_ram_en, a_ram_we, a_p0_rvalid, a_p1_rvalid} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=000000",
                  {a_p0_gnt, a_p1_gnt, a_ram_en, a_ram_we, a_p0_rvalid, a_p1_rvalid});
      end
      checks++;
      if ({a_p0_rdata, a_p1_rdata, a_cnt} !== 80'h0) begin
         failures++;
         $display("FAIL reset_data got=%h/%h/%h exp=0", a_p0_rdata, a_p1_rdata, a_cnt);
      end
      @(negedge clk);
      rstn = 1'b1;
      idle_inputs();
      p0_addr = 15'h0123;
      #1;
      checks++;
      if ({a_ram_en, a_ram_we, a_ram_addr} !== {2'b00, 15'h0123}) begin
         failures++;
         $display("FAIL idle_mux got en=%b we=%b addr=%h exp en=0 we=0 addr=0123",
                  a_ram_en, a_ram_we, a_ram_addr);
      end
      $display("test_reset done");
   endtask

   // Write then immediately read the same word on port 0.
   task automatic test_write_read();
      do_reset();
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 15'h0040; p0_be = 4'hF; p0_wdata = 32'hDEADBEEF;
      #1;
      checks++;
      if ({a_p0_gnt, a_p1_gnt, a_ram_en, a_ram_we, a_ram_addr, a_ram_wdata} !==
          {4'b1011, 15'h0040, 32'hDEADBEEF}) begin
         failures++;
         $display("FAIL wr_issue got gnt=%b%b en=%b we=%b addr=%h wd=%h exp 1011/0040/deadbeef",
                  a_p0_gnt, a_p1_gnt, a_ram_en, a_ram_we, a_ram_addr, a_ram_wdata);
      end
      @(negedge clk);
      p0_we = 1'b0;
      #1;
      checks++;
      if ({a_p0_gnt, a_ram_we, a_p0_rvalid, a_p1_rvalid} !== 4'b1010) begin
         failures++;
         $display("FAIL wr_resp got gnt=%b we=%b rv0=%b rv1=%b exp 1 0 1 0",
                  a_p0_gnt, a_ram_we, a_p0_rvalid, a_p1_rvalid);
      end
      @(negedge clk);
      p0_req = 1'b0;
      #1;
      checks++;
      if ({a_p0_rvalid, a_p1_rvalid, a_p0_rdata, a_p1_rdata} !== {2'b10, 32'hDEADBEEF, 32'h0}) begin
         failures++;
         $display("FAIL rd_resp got rv=%b%b rd0=%h rd1=%h exp 10/deadbeef/0",
                  a_p0_rvalid, a_p1_rvalid, a_p0_rdata, a_p1_rdata);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({a_p0_rvalid, a_p1_rvalid, a_p0_rdata} !== 34'h0) begin
         failures++;
         $display("FAIL rd_idle got rv=%b%b rd0=%h exp 0", a_p0_rvalid, a_p1_rvalid, a_p0_rdata);
      end
      $display("test_write_read done");
   endtask

   task automatic test_byte_write();
      do_reset();
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 15'h0080; p1_be = 4'hF; p1_wdata = 32'h11223344;
      @(negedge clk);
      p1_be = 4'h2; p1_wdata = 32'h0000AB00;
      #1;
      checks++;
      if ({a_p1_gnt, a_ram_we, a_ram_be} !== 6'b11_0010) begin
         failures++;
         $display("FAIL byte_issue got gnt=%b we=%b be=%h exp 1 1 2", a_p1_gnt, a_ram_we, a_ram_be);
      end
      @(negedge clk);
      p1_we = 1'b0;
      @(negedge clk);
      p1_req = 1'b0;
      #1;
      checks++;
      if ({a_p1_rvalid, a_p0_rvalid, a_p1_rdata} !== {2'b10, 32'h1122AB44}) begin
         failures++;
         $display("FAIL byte_read got rv1=%b rv0=%b rd1=%h exp 1 0 1122ab44",
                  a_p1_rvalid, a_p0_rvalid, a_p1_rdata);
      end
      $display("test_byte_write done");
   endtask

   // Six conflict cycles: a alternates 0,1,..., b always grants port 0.
   task automatic test_conflict();
      do_reset();
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 15'h0100; p0_wdata = 32'hA0A00001;
      @(negedge clk);
      idle_inputs();
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 15'h0200; p1_wdata = 32'hB0B00002;
      @(negedge clk);
      do_reset();
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 15'h0100;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 15'h0200;
      for (int k = 0; k <= 6; k++) begin
         if (k == 6) begin
            p0_req = 1'b0; p1_req = 1'b0;
         end
         #1;
         if (k < 6) begin
            checks++;
            if ({a_p0_gnt, a_p1_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01) ||
                a_ram_addr !== ((k % 2 == 0) ? 15'h0100 : 15'h0200)) begin
               failures++;
               $display("FAIL rr_gnt cyc=%0d got gnt=%b%b addr=%h", k, a_p0_gnt, a_p1_gnt, a_ram_addr);
            end
            checks++;
            if ({b_p0_gnt, b_p1_gnt} !== 2'b10) begin
               failures++;
               $display("FAIL fixed_gnt cyc=%0d got gnt=%b%b exp 10", k, b_p0_gnt, b_p1_gnt);
            end
         end
         if (k > 0) begin
            checks++;
            if ((k % 2 == 1) ? ({a_p0_rvalid, a_p1_rvalid, a_p0_rdata} !== {2'b10, 32'hA0A00001})
                             : ({a_p0_rvalid, a_p1_rvalid, a_p1_rdata} !== {2'b01, 32'hB0B00002})) begin
               failures++;
               $display("FAIL rr_rsp cyc=%0d got rv=%b%b rd0=%h rd1=%h",
                        k, a_p0_rvalid, a_p1_rvalid, a_p0_rdata, a_p1_rdata);
            end
            checks++;
            if ({b_p0_rvalid, b_p1_rvalid, b_p0_rdata, b_p1_rdata} !== {2'b10, 32'hA0A00001, 32'h0}) begin
               failures++;
               $display("FAIL fixed_rsp cyc=%0d got rv=%b%b rd0=%h rd1=%h",
                        k, b_p0_rvalid, b_p1_rvalid, b_p0_rdata, b_p1_rdata);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (a_cnt !== 16'd6 || b_cnt !== 16'd6) begin
         failures++;
         $display("FAIL conflict_cnt got a=%0d b=%0d exp 6", a_cnt, b_cnt);
      end
      $display("test_conflict done");
   endtask

   // Reset lands while port 1's response is due; it must vanish.
   task automatic test_reset_mid();
      p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b0; p1_we = 1'b0;
      @(negedge clk);
      p0_req = 1'b0;
      #1;
      checks++;
      if ({a_p0_gnt, a_p1_gnt} !== 2'b01) begin
         failures++;
         $display("FAIL mid_p1_gnt got %b%b exp 01", a_p0_gnt, a_p1_gnt);
      end
      @(negedge clk);
      rstn = 1'b0;
      p0_req = 1'b1; p1_req = 1'b1;
      #1;
      checks++;
      if ({a_p0_gnt, a_p1_gnt, a_ram_en, a_ram_we, a_p0_rvalid, a_p1_rvalid, a_p1_rdata} !== 38'h0) begin
         failures++;
         $display("FAIL mid_forced got gnt=%b%b en=%b rv=%b%b rd1=%h exp 0",
                  a_p0_gnt, a_p1_gnt, a_ram_en, a_p0_rvalid, a_p1_rvalid, a_p1_rdata);
      end
      @(negedge clk);
      #1;
      checks++;
      if (a_cnt !== 16'd0 || a_p1_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL mid_cnt got cnt=%0d rv1=%b exp 0 0", a_cnt, a_p1_rvalid);
      end
      rstn = 1'b1;
      #1;
      checks++;
      if ({a_p0_gnt, a_p1_gnt, a_p1_rvalid} !== 3'b100) begin
         failures++;
         $display("FAIL post_rst_gnt got gnt=%b%b rv1=%b exp 10 0", a_p0_gnt, a_p1_gnt, a_p1_rvalid);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if ({a_p0_rvalid, a_p1_rvalid} !== 2'b10) begin
         failures++;
         $display("FAIL post_rst_rsp got rv=%b%b exp 10", a_p0_rvalid, a_p1_rvalid);
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_saturate();
      do_reset();
      force dut_a.conflict_cnt_q = 16'hFFFE;
      #1;
      release dut_a.conflict_cnt_q;
      p0_req = 1'b1; p1_req = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (a_cnt !== 16'hFFFF || b_cnt !== k[15:0]) begin
            failures++;
            $display("FAIL saturate cyc=%0d got a=%h b=%0d exp ffff %0d", k, a_cnt, b_cnt, k);
         end
      end
      idle_inputs();
      $display("test_saturate done");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_write();
      test_conflict();
      test_reset_mid();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-port request/grant arbiter that shares the single-port SRAM wrapper (32-bit, byte-enabled, one-cycle read latency) between an instruction-fetch requester (port 0) and a data/debug requester (port 1). It issues at most one RAM access per cycle, selects between the ports with round-robin (or fixed-priority) arbitration, and tracks the owner of each access. It returns `rvalid`/`rdata` to that owner one cycle after the grant. A saturating conflict counter is exposed for performance monitoring.

## Interface
- `ADDR_WIDTH`, 15, byte-address width (32 KiB address space), passed through unchanged to the RAM.
- `DATA_WIDTH`, 32, data width; byte enables are `DATA_WIDTH/8` bits wide.
- `FIXED_PRIO`, 0, 0 selects round-robin; 1 means port 0 always wins a conflict.
- `clk`  in  1  single clock for all logic.
- `rstn_i`  in  1  reset, synchronous, active-low.
- `pN_req_i` (N=0,1)  in  1  access request; held with its payload until granted.
- `pN_gnt_o`  out  1  grant; combinational in the request cycle. `req & gnt` means accepted.
- `pN_addr_i`  in  ADDR_WIDTH  byte address.
- `pN_we_i`  in  1  1 = write, 0 = read.
- `pN_be_i`  in  DATA_WIDTH/8  byte enables for writes.
- `pN_wdata_i`  in  DATA_WIDTH  write data.
- `pN_rvalid_o`  out  1  response strobe, one cycle after acceptance; asserted for both reads and writes.
- `pN_rdata_o`  out  DATA_WIDTH  read data; valid only while `pN_rvalid_o`=1, otherwise 0.
- `ram_en_o`  out  1  an access is issued this cycle.
- `ram_we_o`  out  1  write strobe, equal to `ram_en_o & selected we`.
- `ram_addr_o`  out  ADDR_WIDTH  selected address.
- `ram_be_o`  out  DATA_WIDTH/8  selected byte enables.
- `ram_wdata_o`  out  DATA_WIDTH  selected write data.
- `ram_rdata_i`  in  DATA_WIDTH  RAM read data, valid the cycle after issue.
- `conflict_cnt_o`  out  16  count of cycles in which both ports requested; saturates at 0xFFFF.

## Operation
- State registers:
  - `last_gnt`: the port granted in the most recent conflict. Reset value 1, so port 0 wins the first conflict.
  - `rsp_pend`: 1 bit.
  - `rsp_owner`: 1 bit.
  - `conflict_cnt`: 16 bits.
- Arbitration each cycle:
  - Only one port requesting: that port is granted.
  - Both ports requesting, `FIXED_PRIO`=0: grant the port that is not `last_gnt`, then set `last_gnt` to the granted port.
  - Both ports requesting, `FIXED_PRIO`=1: port 0 is always granted; `last_gnt` is unused.
  - `last_gnt` updates only on conflict cycles.
- At most one grant is asserted per cycle. The losing port sees `gnt`=0 and must hold its request.
- RAM mux:
  - When a port is granted, the `ram_*` outputs carry that port's payload and `ram_en_o`=1.
  - When idle: `ram_en_o`=0, `ram_we_o`=0, and `ram_addr_o`/`ram_be_o`/`ram_wdata_o` carry port 0's inputs, which the RAM ignores.
- Response path:
  - On a grant, `rsp_pend` is set to 1 and `rsp_owner` to the granted port at the clock edge; otherwise `rsp_pend` is cleared.
  - In the next cycle, `p[rsp_owner]_rvalid_o`=1 and `p[rsp_owner]_rdata_o`=`ram_rdata_i`. The other port's `rdata` is 0.
  - Write responses return the same `rvalid`; their `rdata` content is don't-care but is driven from `ram_rdata_i`.
- Back-to-back operation:
  - A new grant may coincide with the response of the previous access, giving full throughput of one access per cycle.
  - Responses never reorder.
- Conflict counter: increments on every cycle with `p0_req_i & p1_req_i`, independent of `FIXED_PRIO`. It holds at 0xFFFF.

## Timing
- Grant path: combinational `req` -> `gnt` -> `ram_*`, in the same cycle. The RAM samples on the rising edge.
- Latency:
  - Response: exactly 1 cycle from acceptance to `rvalid`.
  - Read data: read data is that of the address accepted in the previous cycle.
- Reset (`rstn_i`=0 sampled on a rising edge):
  - Registers: `last_gnt`=1, `rsp_pend`=0, `conflict_cnt`=0.
  - While `rstn_i` is low, all outputs are forced combinationally: `gnt`=0, `ram_en_o`=0, `ram_we_o`=0, `rvalid`=0, `rdata`=0.
- Reset mid-operation: an outstanding response is discarded and no `rvalid` is issued after reset. Requesters re-issue their requests.
- A write followed by a read of the same address in the next cycle returns the new data, because the RAM write completes at the edge.
- A request deasserted without a grant is legal and leaves no state behind.

## Test plan
- Single port 0 read of 0x0040 after a write of 0xDEADBEEF (`be`=0xF) -> `gnt` in the same cycle, `p0_rvalid_o` next cycle, `p0_rdata_o`=0xDEADBEEF, `p1_rvalid_o`=0 throughout.
- Both ports requesting continuously for 6 cycles, `FIXED_PRIO`=0 -> grants alternate 0,1,0,1,0,1, each `rvalid` goes to the matching port one cycle later, `conflict_cnt_o`=6.
- Same stimulus with `FIXED_PRIO`=1 -> port 0 granted all 6 cycles, port 1 never granted, `conflict_cnt_o`=6.
- Byte write `be`=0x2, `wdata`=0x0000AB00 over 0x11223344, then read -> `rdata`=0x1122AB44.
- `rstn_i` low in the cycle after a port 1 grant -> no `p1_rvalid_o`, all outputs 0 during reset, `conflict_cnt_o`=0, and the first post-reset conflict grants port 0.
- Force `conflict_cnt` to 0xFFFE, then 3 conflict cycles -> `conflict_cnt_o` reads 0xFFFF and stays there.
